mips_multicycle_ctrl: RTL and testbench

//  Multi-cycle sequencer for the ALU/register-file datapath driven by mips_decode.
//  - Accepts one 32-bit instruction per valid/ready handshake and decodes it.
//  - Drives register-file read, ALU control and writeback in separate cycles.
//  - Flags illegal instructions and counts retired instructions.
//  - Sits between the instruction source (fetch/testbench) and the datapath.

---
 rtl/mips_multicycle_ctrl_pkg.sv | 40 ++++
 rtl/mips_multicycle_ctrl_decode.sv | 56 +++++
 rtl/mips_multicycle_ctrl.sv | 110 +++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared opcode/funct codes, ALU op codes and FSM state encoding for the controller.
// Latency: none (constants and a pure function).
// Backpressure: not applicable.
package mips_multicycle_ctrl_pkg;

  // Primary opcodes (inst[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;

  // R-format function codes (inst[5:0])
  localparam logic [5:0] OP0_ADD = 6'h20;
  localparam logic [5:0] OP0_SUB = 6'h22;
  localparam logic [5:0] OP0_AND = 6'h24;
  localparam logic [5:0] OP0_OR  = 6'h25;
  localparam logic [5:0] OP0_XOR = 6'h26;
  localparam logic [5:0] OP0_NOR = 6'h27;

  // ALU op codes
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;
  localparam logic [2:0] ALU_OR  = 3'd5;
  localparam logic [2:0] ALU_NOR = 3'd6;
  localparam logic [2:0] ALU_XOR = 3'd7;

  // FSM states, IDLE must stay 0 so a cleared register is idle
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_WB     = 3'd3;
  localparam logic [2:0] ST_EXC    = 3'd4;

  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_decode.sv
// Combinational opcode/funct decoder: ALU op, write enable, dest select, operand select, illegal flag.
// Latency: zero cycles (purely combinational).
// Backpressure: none; the outputs track the opcode/funct inputs.
// Ports: opcode, funct in; alu_op, writeenable, rd_src, alu_src2, except out.
module mips_decode
  import mips_multicycle_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       writeenable,
  output logic       rd_src,
  output logic       alu_src2,
  output logic       except
);

  always_comb begin
    alu_op      = 3'd0;
    writeenable = 1'b0;
    rd_src      = 1'b0;
    alu_src2    = 1'b0;
    except      = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        except      = 1'b0;
        writeenable = 1'b1;
        case (funct)
          OP0_ADD: alu_op = ALU_ADD;
          OP0_SUB: alu_op = ALU_SUB;
          OP0_AND: alu_op = ALU_AND;
          OP0_OR:  alu_op = ALU_OR;
          OP0_NOR: alu_op = ALU_NOR;
          OP0_XOR: alu_op = ALU_XOR;
          default: begin
            except      = 1'b1;
            writeenable = 1'b0;
          end
        endcase
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: begin
        except      = 1'b0;
        writeenable = 1'b1;
        rd_src      = 1'b1;
        alu_src2    = 1'b1;
        case (opcode)
          OP_ADDI: alu_op = ALU_ADD;
          OP_ANDI: alu_op = ALU_AND;
          OP_ORI:  alu_op = ALU_OR;
          default: alu_op = ALU_XOR;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle sequencer: accept instruction, DECODE (rf read), EXEC, WB (write/retire) or EXC (drop).
// Latency: accept->writeback 3 cycles, next accept 4 cycles later; EXC exits one cycle earlier.
// Backpressure: inst_ready only in IDLE without flush; wb_stall holds WB; flush aborts to IDLE.
// Ports: clock/reset(async low); inst_valid/inst/inst_ready handshake; flush, wb_stall controls;
//        rf_rs_num/rf_rt_num/rf_re reads; imm_ext/alu_op/alu_src2 ALU; rf_wr_num/rf_we write;
//        retire/except pulses; busy; retired_count.
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inst_valid,
  input  logic [31:0]      inst,
  output logic             inst_ready,
  input  logic             flush,
  input  logic             wb_stall,
  output logic [4:0]       rf_rs_num,
  output logic [4:0]       rf_rt_num,
  output logic             rf_re,
  output logic [31:0]      imm_ext,
  output logic [2:0]       alu_op,
  output logic             alu_src2,
  output logic [4:0]       rf_wr_num,
  output logic             rf_we,
  output logic             retire,
  output logic             except,
  output logic             busy,
  output logic [CNT_W-1:0] retired_count
);

  logic [2:0]  state_q, state_nxt;
  logic [31:0] instr_q;

  logic [2:0]  dec_alu_op;
  logic        dec_we, dec_rd_src, dec_alu_src2, dec_except;

  logic [2:0]  alu_op_q;
  logic        we_q, rd_src_q, alu_src2_q;
  logic [CNT_W-1:0] cnt_q;

  mips_decode u_decode (
    .opcode      (instr_q[31:26]),
    .funct       (instr_q[5:0]),
    .alu_op      (dec_alu_op),
    .writeenable (dec_we),
    .rd_src      (dec_rd_src),
    .alu_src2    (dec_alu_src2),
    .except      (dec_except)
  );

  assign inst_ready = (state_q == ST_IDLE) && !flush;

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:   if (inst_valid && inst_ready) state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = dec_except ? ST_EXC : ST_EXEC;
      ST_EXEC:   state_nxt = ST_WB;
      ST_WB:     if (!wb_stall) state_nxt = ST_IDLE;
      ST_EXC:    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    // flush wins over stall and over the exception path
    if (flush && (state_q != ST_IDLE)) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      instr_q    <= '0;
      alu_op_q   <= '0;
      we_q       <= 1'b0;
      rd_src_q   <= 1'b0;
      alu_src2_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_nxt;
      if (inst_valid && inst_ready) instr_q <= inst;
      if (state_q == ST_DECODE) begin
        alu_op_q   <= dec_alu_op;
        we_q       <= dec_we;
        rd_src_q   <= dec_rd_src;
        alu_src2_q <= dec_alu_src2;
      end
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // In DECODE the registered copies are not loaded yet, so present the live decode
  logic in_decode;
  logic rd_src_sel;
  assign in_decode  = (state_q == ST_DECODE);
  assign rd_src_sel = in_decode ? dec_rd_src : rd_src_q;

  assign rf_rs_num     = instr_q[25:21];
  assign rf_rt_num     = instr_q[20:16];
  assign imm_ext       = sign_ext16(instr_q[15:0]);
  assign rf_re         = in_decode;
  assign alu_op        = in_decode ? dec_alu_op   : alu_op_q;
  assign alu_src2      = in_decode ? dec_alu_src2 : alu_src2_q;
  assign rf_wr_num     = rd_src_sel ? instr_q[20:16] : instr_q[15:11];
  assign retire        = (state_q == ST_WB) && !wb_stall && !flush;
  assign rf_we         = retire && we_q;
  assign except        = (state_q == ST_EXC) && !flush;
  assign busy          = (state_q != ST_IDLE);
  assign retired_count = cnt_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for the multi-cycle controller, CNT_W=4 so the counter wrap is reachable.
// Inputs driven 1ns after each rising edge; outputs sampled at that point.
module tb_mips_multicycle_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        inst_valid = 1'b0;
  logic [31:0] inst = '0;
  logic        inst_ready;
  logic        flush = 1'b0;
  logic        wb_stall = 1'b0;
  logic [4:0]  rf_rs_num, rf_rt_num, rf_wr_num;
  logic        rf_re, alu_src2, rf_we, retire, except, busy;
  logic [31:0] imm_ext;
  logic [2:0]  alu_op;
  logic [3:0]  retired_count;

  int checks = 0;
  int failures = 0;

  mips_multicycle_ctrl #(.CNT_W(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_ready    (inst_ready),
    .flush         (flush),
    .wb_stall      (wb_stall),
    .rf_rs_num     (rf_rs_num),
    .rf_rt_num     (rf_rt_num),
    .rf_re         (rf_re),
    .imm_ext       (imm_ext),
    .alu_op        (alu_op),
    .alu_src2      (alu_src2),
    .rf_wr_num     (rf_wr_num),
    .rf_we         (rf_we),
    .retire        (retire),
    .except        (except),
    .busy          (busy),
    .retired_count (retired_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present an instruction for one cycle and let it be accepted; returns in DECODE.
  task automatic issue(input logic [31:0] word);
    inst_valid = 1'b1;
    inst       = word;
    chk("issue_ready", inst_ready, 1);
    step();
    inst_valid = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_ready", inst_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_retire", retire, 0);
    chk("rst_except", except, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_imm", imm_ext, 0);
    chk("rst_count", retired_count, 0);
    step();
    reset = 1'b1;
    step();

    // add $3,$1,$2
    issue(32'h00221820);
    chk("add_dec_rf_re", rf_re, 1);
    chk("add_dec_busy", busy, 1);
    chk("add_dec_ready", inst_ready, 0);
    chk("add_dec_alu_op", alu_op, 2);
    chk("add_dec_rs", rf_rs_num, 1);
    chk("add_dec_rt", rf_rt_num, 2);
    step();
    chk("add_ex_rf_re", rf_re, 0);
    chk("add_ex_alu_op", alu_op, 2);
    chk("add_ex_wr", rf_wr_num, 3);
    chk("add_ex_we", rf_we, 0);
    step();
    chk("add_wb_we", rf_we, 1);
    chk("add_wb_retire", retire, 1);
    chk("add_wb_count", retired_count, 0);
    step();
    chk("add_idle_retire", retire, 0);
    chk("add_idle_count", retired_count, 1);
    chk("add_idle_ready", inst_ready, 1);

    // addi $5,$4,7
    issue(32'h20850007);
    chk("addi_src2", alu_src2, 1);
    chk("addi_imm", imm_ext, 32'h00000007);
    chk("addi_alu_op", alu_op, 2);
    chk("addi_rs", rf_rs_num, 4);
    step();
    chk("addi_wr", rf_wr_num, 5);
    chk("addi_ex_src2", alu_src2, 1);
    step();
    chk("addi_wb_we", rf_we, 1);
    step();
    chk("addi_count", retired_count, 2);

    // negative immediate: andi $2,$1,0x8001 sign-extends
    issue(32'h30228001);
    chk("andi_imm", imm_ext, 32'hFFFF8001);
    chk("andi_alu_op", alu_op, 4);
    step(); step(); step();
    chk("andi_count", retired_count, 3);

    // illegal opcode
    issue(32'hFC000000);
    chk("ill_dec_rf_re", rf_re, 1);
    step();
    chk("ill_except", except, 1);
    chk("ill_we", rf_we, 0);
    chk("ill_retire", retire, 0);
    chk("ill_ready_busy", inst_ready, 0);
    step();
    chk("ill_except_off", except, 0);
    chk("ill_ready", inst_ready, 1);
    chk("ill_count", retired_count, 3);

    // wb_stall for three cycles then release
    issue(32'h00223026);
    step(); step();
    wb_stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_we", rf_we, 0);
      chk("stall_retire", retire, 0);
      chk("stall_busy", busy, 1);
      step();
    end
    wb_stall = 1'b0;
    #1;
    chk("stall_rel_we", rf_we, 1);
    chk("stall_rel_retire", retire, 1);
    chk("stall_rel_wr", rf_wr_num, 6);
    step();
    chk("stall_count", retired_count, 4);
    chk("stall_idle", busy, 0);

    // flush while stalled in WB
    issue(32'h00221820);
    step(); step();
    wb_stall = 1'b1;
    step();
    flush = 1'b1;
    #1;
    chk("flush_we", rf_we, 0);
    chk("flush_retire", retire, 0);
    step();
    chk("flush_idle_busy", busy, 0);
    chk("flush_idle_ready", inst_ready, 0);
    flush    = 1'b0;
    wb_stall = 1'b0;
    #1;
    chk("flush_ready_back", inst_ready, 1);
    chk("flush_count", retired_count, 4);

    // flush on an illegal instruction suppresses except
    issue(32'hFC000000);
    flush = 1'b1;
    step();
    chk("flush_exc_except", except, 0);
    chk("flush_exc_busy", busy, 0);
    flush = 1'b0;
    step();
    chk("flush_exc_except2", except, 0);

    // async reset in EXEC
    issue(32'h20850007);
    step();
    chk("pre_rst_busy", busy, 1);
    #1 reset = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ready", inst_ready, 1);
    chk("arst_alu_op", alu_op, 0);
    chk("arst_src2", alu_src2, 0);
    chk("arst_imm", imm_ext, 0);
    chk("arst_count", retired_count, 0);
    step();
    chk("arst_hold_busy", busy, 0);
    reset = 1'b1;
    step();
    chk("arst_rel_ready", inst_ready, 1);
    chk("arst_rel_busy", busy, 0);

    // 16 back-to-back xor instructions; counter wraps 15->0
    inst       = 32'h00223026;
    inst_valid = 1'b1;
    for (int i = 0; i <= 64; i++) begin
      chk("b2b_ready", inst_ready, (i % 4 == 0) ? 1 : 0);
      chk("b2b_retire", retire, (i % 4 == 3) ? 1 : 0);
      if (i == 60) chk("b2b_count15", retired_count, 15);
      if (i == 64) begin
        chk("b2b_wrap", retired_count, 0);
        inst_valid = 1'b0;
      end else begin
        step();
      end
    end
    step();
    chk("b2b_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
